// File: rtl/afoote_w5s8_tt02_tape_driver_pkg.sv
// Shared definitions for the UTM tape driver: FSM states, symbol width, head direction encoding
// and the default halt state.
package afoote_w5s8_tt02_tape_driver_pkg;

  localparam int SYM_W = 3;

  localparam logic [SYM_W-1:0] HALT_STATE_DEFAULT = 3'd7;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_PRESENT,
    ST_EXEC,
    ST_DONE
  } state_t;

  function automatic logic state_is_busy(input state_t s);
    return (s == ST_CLR) || (s == ST_PRESENT) || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/afoote_w5s8_tt02_tape_mem.sv
// Tape register file: DEPTH cells of SYM_W bits, one write port, two asynchronous read ports
// (head and host), cleared synchronously on reset.
module afoote_w5s8_tt02_tape_mem
  import afoote_w5s8_tt02_tape_driver_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [SYM_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_head_addr,
  output logic [SYM_W-1:0]  o_head_data,
  input  logic [ADDR_W-1:0] i_host_addr,
  output logic [SYM_W-1:0]  o_host_data
);

  logic [SYM_W-1:0] r_cells [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cells[i] <= '0;
      end
    end else if (i_we) begin
      r_cells[i_waddr] <= i_wdata;
    end
  end

  assign o_head_data = r_cells[i_head_addr];
  assign o_host_data = r_cells[i_host_addr];

endmodule

// File: rtl/afoote_w5s8_tt02_tape_driver.sv
// Tape side of the UTM step interface: presents the symbol under the head, writes back the core's
// symbol and moves the head. Define TAPE_DRIVER_WRAP_EN to make the head wrap instead of faulting.
module afoote_w5s8_tt02_tape_driver
  import afoote_w5s8_tt02_tape_driver_pkg::*;
#(
  parameter int               DEPTH      = 16,
  parameter int               ADDR_W     = $clog2(DEPTH),
  parameter int               START_HEAD = 8,
  parameter logic [SYM_W-1:0] HALT_STATE = HALT_STATE_DEFAULT,
  parameter int               STEP_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [SYM_W-1:0]  i_host_wdata,
  output logic [SYM_W-1:0]  o_host_rdata,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_head,
  output logic [STEP_W-1:0] o_steps,
  output logic              o_core_reset,
  output logic [SYM_W-1:0]  o_core_sym,
  output logic              o_core_sym_valid,
  input  logic [SYM_W-1:0]  i_core_new_sym,
  input  logic              i_core_dir,
  input  logic [SYM_W-1:0]  i_core_next_state
);

`ifdef TAPE_DRIVER_WRAP_EN
  localparam logic EDGE_FAULT_EN = 1'b0;
`else
  localparam logic EDGE_FAULT_EN = 1'b1;
`endif

  localparam logic [ADDR_W-1:0] HEAD_START = ADDR_W'(START_HEAD);
  localparam logic [ADDR_W-1:0] HEAD_LAST  = ADDR_W'(DEPTH - 1);
  // Value of the step counter going into the last step the budget allows.
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'((2 ** STEP_W) - 2);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] w_head_next;
  logic [STEP_W-1:0] r_steps;
  logic [STEP_W-1:0] w_steps_next;
  logic              r_halted;
  logic              w_halted_next;
  logic              r_fault;
  logic              w_fault_next;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [SYM_W-1:0]  w_mem_wdata;
  logic [SYM_W-1:0]  w_head_sym;
  logic [ADDR_W-1:0] w_head_left;
  logic [ADDR_W-1:0] w_head_right;
  logic              w_at_edge;

  afoote_w5s8_tt02_tape_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tape_mem (
    .clock       (clock),
    .reset       (reset),
    .i_we        (w_mem_we),
    .i_waddr     (w_mem_waddr),
    .i_wdata     (w_mem_wdata),
    .i_head_addr (r_head),
    .o_head_data (w_head_sym),
    .i_host_addr (i_host_addr),
    .o_host_data (o_host_rdata)
  );

  // Modulo neighbours; without wrap the edge fault fires before these are ever used at an edge.
  assign w_head_left  = (r_head == '0) ? HEAD_LAST : r_head - 1'b1;
  assign w_head_right = (r_head == HEAD_LAST) ? '0 : r_head + 1'b1;
  assign w_at_edge    = ((i_core_dir == DIR_LEFT) && (r_head == '0)) ||
                        ((i_core_dir == DIR_RIGHT) && (r_head == HEAD_LAST));

  always_comb begin
    w_state_next     = r_state;
    w_head_next      = r_head;
    w_steps_next     = r_steps;
    w_halted_next    = r_halted;
    w_fault_next     = r_fault;
    w_mem_we         = 1'b0;
    w_mem_waddr      = i_host_addr;
    w_mem_wdata      = i_host_wdata;
    o_core_reset     = 1'b0;
    o_core_sym_valid = 1'b0;
    o_core_sym       = '0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        o_core_reset = 1'b1;
        w_mem_we     = i_host_we;
        if (i_start) begin
          w_head_next   = HEAD_START;
          w_steps_next  = '0;
          w_halted_next = 1'b0;
          w_fault_next  = 1'b0;
          w_state_next  = ST_CLR;
        end
      end
      ST_CLR: begin
        w_state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        o_core_sym       = w_head_sym;
        o_core_sym_valid = 1'b1;
        w_state_next     = ST_EXEC;
      end
      ST_EXEC: begin
        w_mem_we     = 1'b1;
        w_mem_waddr  = r_head;
        w_mem_wdata  = i_core_new_sym;
        w_steps_next = r_steps + 1'b1;
        if (i_core_next_state == HALT_STATE) begin
          w_halted_next = 1'b1;
          w_state_next  = ST_DONE;
        end else if (r_steps == STEP_LAST) begin
          w_fault_next = 1'b1;
          w_state_next = ST_DONE;
        end else if (EDGE_FAULT_EN && w_at_edge) begin
          w_fault_next = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_head_next  = (i_core_dir == DIR_RIGHT) ? w_head_right : w_head_left;
          w_state_next = ST_PRESENT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_head   <= HEAD_START;
      r_steps  <= '0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_head   <= w_head_next;
      r_steps  <= w_steps_next;
      r_halted <= w_halted_next;
      r_fault  <= w_fault_next;
    end
  end

  assign o_busy   = state_is_busy(r_state);
  assign o_halted = r_halted;
  assign o_fault  = r_fault;
  assign o_head   = r_head;
  assign o_steps  = r_steps;

endmodule
